// File: rtl/player_motion_ctrl.sv
// Player position/heading controller: key commands -> turn or wall-checked step, rate-limited by frame ticks.
// Optional build macro KEY_REPEAT_EN: a held key re-issues its command each time cooldown ends.
module player_motion_ctrl #(
    parameter int GRID_W          = 20,
    parameter int GRID_H          = 20,
    parameter int START_X         = 0,
    parameter int START_Y         = 0,
    parameter int START_DIR       = 0,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ACK_TIMEOUT     = 16
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic       key_fwd,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       frame_tick,
    output logic       wall_query_req,
    output logic [4:0] wall_query_x,
    output logic [4:0] wall_query_y,
    output logic [1:0] wall_query_dir,
    input  logic       wall_query_ack,
    input  logic       wall_blocked,
    output logic [4:0] player_x,
    output logic [4:0] player_y,
    output logic [1:0] player_dir,
    output logic       move_done,
    output logic       query_timeout
);

    // state    | meaning
    // IDLE     | waiting for a pending command
    // QUERY    | wall lookup outstanding for a forward step
    // STEP     | position just updated, move_done high
    // COOLDOWN | waiting COOLDOWN_FRAMES frame ticks
    typedef enum logic [1:0] {S_IDLE, S_QUERY, S_STEP, S_COOLDOWN} state_t;
    typedef enum logic [1:0] {CMD_NONE, CMD_FWD, CMD_LEFT, CMD_RIGHT} cmd_t;

    localparam logic signed [5:0] L_GRID_W = 6'(GRID_W);
    localparam logic signed [5:0] L_GRID_H = 6'(GRID_H);

    state_t r_state, w_state_nxt;
    cmd_t   r_pend, w_pend_nxt, w_edge_cmd;

    // bit 0 = fwd, bit 1 = left, bit 2 = right
    logic [2:0] r_sync1, r_sync2, r_key_d;
    logic [2:0] w_key_rise;

    logic [4:0] r_x, r_y;
    logic [1:0] r_dir;
    logic [7:0] r_cd_cnt;
    logic [7:0] r_ack_cnt;
    logic       r_move_done, r_timeout;
    logic       w_consume;

    logic signed [5:0] w_tgt_x, w_tgt_y;
    logic              w_tgt_ok;

    assign w_key_rise = r_sync2 & ~r_key_d;

    always_comb begin
        w_edge_cmd = CMD_NONE;
        if (w_key_rise[0])      w_edge_cmd = CMD_FWD;
        else if (w_key_rise[1]) w_edge_cmd = CMD_LEFT;
        else if (w_key_rise[2]) w_edge_cmd = CMD_RIGHT;
    end

`ifdef KEY_REPEAT_EN
    cmd_t w_rep_cmd;

    always_comb begin
        w_rep_cmd = CMD_NONE;
        if (r_sync2[0])      w_rep_cmd = CMD_FWD;
        else if (r_sync2[1]) w_rep_cmd = CMD_LEFT;
        else if (r_sync2[2]) w_rep_cmd = CMD_RIGHT;
    end
`endif

    // Signed 6-bit target so that -1 and GRID_W/GRID_H are both detectable.
    always_comb begin
        w_tgt_x = $signed({1'b0, r_x});
        w_tgt_y = $signed({1'b0, r_y});
        case (r_dir)
            2'd0:    w_tgt_x = $signed({1'b0, r_x}) + 6'sd1;
            2'd1:    w_tgt_y = $signed({1'b0, r_y}) - 6'sd1;
            2'd2:    w_tgt_x = $signed({1'b0, r_x}) - 6'sd1;
            default: w_tgt_y = $signed({1'b0, r_y}) + 6'sd1;
        endcase
        w_tgt_ok = (w_tgt_x >= 6'sd0) && (w_tgt_x < L_GRID_W) &&
                   (w_tgt_y >= 6'sd0) && (w_tgt_y < L_GRID_H);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_consume   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend != CMD_NONE) begin
                    w_consume = 1'b1;
                    if (r_pend == CMD_FWD && w_tgt_ok) w_state_nxt = S_QUERY;
                    else                               w_state_nxt = S_COOLDOWN;
                end
            end
            S_QUERY: begin
                if (wall_query_ack)       w_state_nxt = wall_blocked ? S_COOLDOWN : S_STEP;
                else if (r_ack_cnt == 0)  w_state_nxt = S_COOLDOWN;
            end
            S_STEP:     w_state_nxt = S_COOLDOWN;
            S_COOLDOWN: if (r_cd_cnt == 0) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Newest edge always wins; a consumed command is cleared unless replaced the same cycle.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_consume) w_pend_nxt = CMD_NONE;
`ifdef KEY_REPEAT_EN
        if (r_state == S_COOLDOWN && w_state_nxt == S_IDLE && r_pend == CMD_NONE &&
            w_rep_cmd != CMD_NONE)
            w_pend_nxt = w_rep_cmd;
`endif
        if (w_edge_cmd != CMD_NONE) w_pend_nxt = w_edge_cmd;
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_pend      <= CMD_NONE;
            r_sync1     <= 3'b000;
            r_sync2     <= 3'b000;
            r_key_d     <= 3'b000;
            r_x         <= 5'(START_X);
            r_y         <= 5'(START_Y);
            r_dir       <= 2'(START_DIR);
            r_cd_cnt    <= 8'd0;
            r_ack_cnt   <= 8'd0;
            r_move_done <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_sync1     <= {key_right, key_left, key_fwd};
            r_sync2     <= r_sync1;
            r_key_d     <= r_sync2;
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_move_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_pend == CMD_LEFT) begin
                        r_dir       <= r_dir + 2'd1;
                        r_move_done <= 1'b1;
                    end else if (r_pend == CMD_RIGHT) begin
                        r_dir       <= r_dir - 2'd1;
                        r_move_done <= 1'b1;
                    end else if (r_pend == CMD_FWD) begin
                        r_ack_cnt   <= 8'(ACK_TIMEOUT - 1);
                    end
                end
                S_QUERY: begin
                    // Position is stable during QUERY, so the live target is still valid at ack.
                    if (wall_query_ack) begin
                        if (!wall_blocked) begin
                            r_x         <= w_tgt_x[4:0];
                            r_y         <= w_tgt_y[4:0];
                            r_move_done <= 1'b1;
                        end
                    end else if (r_ack_cnt == 0) begin
                        r_timeout <= 1'b1;
                    end else begin
                        r_ack_cnt <= r_ack_cnt - 8'd1;
                    end
                end
                S_COOLDOWN: begin
                    if (frame_tick && r_cd_cnt != 0) r_cd_cnt <= r_cd_cnt - 8'd1;
                end
                default: ;
            endcase
            // Loading on the entry edge overrides any tick seen in that cycle.
            if (w_state_nxt == S_COOLDOWN && r_state != S_COOLDOWN)
                r_cd_cnt <= 8'(COOLDOWN_FRAMES);
        end
    end

    assign wall_query_req = (r_state == S_QUERY);
    assign wall_query_x   = r_x;
    assign wall_query_y   = r_y;
    assign wall_query_dir = r_dir;
    assign player_x       = r_x;
    assign player_y       = r_y;
    assign player_dir     = r_dir;
    assign move_done      = r_move_done;
    assign query_timeout  = r_timeout;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Self-checking bench for player_motion_ctrl: directed table, boundary walks, timeout/reset
// sequences and randomized commands against a transaction-level position model.
module tb_player_motion_ctrl;

    localparam int GW   = 20;
    localparam int GH   = 20;
    localparam int CDF  = 8;
    localparam int ACKT = 16;
    localparam int C_FWD = 1, C_LEFT = 2, C_RIGHT = 4;

    logic       vga_clock = 1'b0;
    logic       reset = 1'b1;
    logic       key_fwd = 1'b0, key_left = 1'b0, key_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic       wall_query_ack = 1'b0, wall_blocked = 1'b0;
    logic       wall_query_req;
    logic [4:0] wall_query_x, wall_query_y, player_x, player_y;
    logic [1:0] wall_query_dir, player_dir;
    logic       move_done, query_timeout;

    player_motion_ctrl #(
        .GRID_W(GW), .GRID_H(GH), .START_X(0), .START_Y(0), .START_DIR(0),
        .COOLDOWN_FRAMES(CDF), .ACK_TIMEOUT(ACKT)
    ) dut (
        .vga_clock(vga_clock), .reset(reset),
        .key_fwd(key_fwd), .key_left(key_left), .key_right(key_right),
        .frame_tick(frame_tick),
        .wall_query_req(wall_query_req), .wall_query_x(wall_query_x),
        .wall_query_y(wall_query_y), .wall_query_dir(wall_query_dir),
        .wall_query_ack(wall_query_ack), .wall_blocked(wall_blocked),
        .player_x(player_x), .player_y(player_y), .player_dir(player_dir),
        .move_done(move_done), .query_timeout(query_timeout)
    );

    always #5 vga_clock = ~vga_clock;

    int n_checks = 0, n_fail = 0;
    int m_x = 0, m_y = 0, m_dir = 0;
    bit m_to = 0;
    int done_cnt = 0, req_seen = 0, req_cnt = 0, last_req_len = 0;
    bit rsp_blk = 0, rsp_noack = 0, q_chk = 1;
    int rsp_dly = 0;

    typedef struct {
        int mask; bit blk; int dly;
        int ex; int ey; int edir; int edone; int ereq;
    } vec_t;
    vec_t tbl[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Wall responder and pulse monitor, sampled on the falling edge.
    always @(negedge vga_clock) begin
        if (move_done) done_cnt++;
        if (wall_query_req) begin
            req_seen++;
            req_cnt++;
            if (req_cnt == 1 && q_chk) begin
                check("query_x", int'(wall_query_x), m_x);
                check("query_y", int'(wall_query_y), m_y);
                check("query_dir", int'(wall_query_dir), m_dir);
            end
            wall_query_ack = !rsp_noack && (req_cnt == rsp_dly + 1);
            wall_blocked   = wall_query_ack ? rsp_blk : 1'($urandom);
        end else begin
            if (req_cnt > 0) last_req_len = req_cnt;
            req_cnt        = 0;
            wall_query_ack = 1'b0;
            wall_blocked   = 1'($urandom);
        end
    end

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge vga_clock); #1 frame_tick = 1'b1;
            @(posedge vga_clock); #1 frame_tick = 1'b0;
        end
    endtask

    task automatic press(input int mask);
        @(posedge vga_clock); #1;
        key_fwd   = (mask & C_FWD)   != 0;
        key_left  = (mask & C_LEFT)  != 0;
        key_right = (mask & C_RIGHT) != 0;
        repeat (4) @(posedge vga_clock);
        #1 {key_fwd, key_left, key_right} = 3'b000;
    endtask

    task automatic do_cmd(input int mask, input bit blk, input int dly, input bit noack);
        rsp_blk = blk; rsp_dly = dly; rsp_noack = noack;
        @(posedge vga_clock); #1;
        done_cnt = 0; req_seen = 0;
        press(mask);
        repeat (30) @(posedge vga_clock);
        ticks(CDF);
        repeat (4) @(posedge vga_clock);
        #1;
    endtask

    task automatic model_cmd(input int mask, input bit blk, input bit noack,
                             output int e_done, output int e_req);
        int tx, ty;
        e_done = 0; e_req = 0;
        if ((mask & C_FWD) != 0) begin
            tx = m_x; ty = m_y;
            case (m_dir)
                0: tx++;
                1: ty--;
                2: tx--;
                default: ty++;
            endcase
            if (tx >= 0 && tx < GW && ty >= 0 && ty < GH) begin
                e_req = 1;
                if (noack) m_to = 1;
                else if (!blk) begin m_x = tx; m_y = ty; e_done = 1; end
            end
        end else if ((mask & C_LEFT) != 0) begin
            m_dir = (m_dir + 1) % 4; e_done = 1;
        end else if ((mask & C_RIGHT) != 0) begin
            m_dir = (m_dir + 3) % 4; e_done = 1;
        end
    endtask

    task automatic run_cmd(input string tag, input int mask, input bit blk, input int dly,
                           input bit noack);
        int e_done, e_req;
        do_cmd(mask, blk, dly, noack);
        model_cmd(mask, blk, noack, e_done, e_req);
        check({tag, " x"}, int'(player_x), m_x);
        check({tag, " y"}, int'(player_y), m_y);
        check({tag, " dir"}, int'(player_dir), m_dir);
        check({tag, " move_done pulses"}, done_cnt, e_done);
        check({tag, " req seen"}, int'(req_seen > 0), e_req);
        check({tag, " timeout"}, int'(query_timeout), int'(m_to));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " x"}, int'(player_x), 0);
        check({tag, " y"}, int'(player_y), 0);
        check({tag, " dir"}, int'(player_dir), 0);
        check({tag, " req"}, int'(wall_query_req), 0);
        check({tag, " move_done"}, int'(move_done), 0);
        check({tag, " timeout"}, int'(query_timeout), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, exp_steps, waited;

        tbl[0]  = '{C_LEFT,  0, 0, 0, 0, 1, 1, 0};
        tbl[1]  = '{C_FWD,   0, 0, 0, 0, 1, 0, 0};
        tbl[2]  = '{C_RIGHT, 0, 0, 0, 0, 0, 1, 0};
        tbl[3]  = '{C_RIGHT, 0, 0, 0, 0, 3, 1, 0};
        tbl[4]  = '{C_FWD,   0, 2, 0, 1, 3, 1, 1};
        tbl[5]  = '{C_FWD,   1, 0, 0, 1, 3, 0, 1};
        tbl[6]  = '{C_RIGHT, 0, 0, 0, 1, 2, 1, 0};
        tbl[7]  = '{C_FWD,   0, 0, 0, 1, 2, 0, 0};
        tbl[8]  = '{C_LEFT,  0, 0, 0, 1, 3, 1, 0};
        tbl[9]  = '{C_LEFT,  0, 0, 0, 1, 0, 1, 0};
        tbl[10] = '{C_FWD,   0, 0, 1, 1, 0, 1, 1};
        tbl[11] = '{C_FWD,   0, 3, 2, 1, 0, 1, 1};

        repeat (3) @(posedge vga_clock);
        #1 check_reset_state("reset");
        @(negedge vga_clock); reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            do_cmd(tbl[i].mask, tbl[i].blk, tbl[i].dly, 1'b0);
            check($sformatf("vec%0d x", i), int'(player_x), tbl[i].ex);
            check($sformatf("vec%0d y", i), int'(player_y), tbl[i].ey);
            check($sformatf("vec%0d dir", i), int'(player_dir), tbl[i].edir);
            check($sformatf("vec%0d move_done", i), done_cnt, tbl[i].edone);
            check($sformatf("vec%0d req", i), int'(req_seen > 0), tbl[i].ereq);
            m_x = tbl[i].ex; m_y = tbl[i].ey; m_dir = tbl[i].edir;
        end

        // Walk to the east edge, then the south edge, and bump into both.
        while (m_x < GW - 1) run_cmd("walk_e", C_FWD, 0, 1, 0);
        run_cmd("edge_e", C_FWD, 0, 0, 0);
        run_cmd("turn_s", C_RIGHT, 0, 0, 0);
        while (m_y < GH - 1) run_cmd("walk_s", C_FWD, 0, 0, 0);
        run_cmd("edge_s", C_FWD, 0, 0, 0);
        run_cmd("turn_w", C_RIGHT, 0, 0, 0);

        // Ack never arrives: req held ACK_TIMEOUT cycles, then sticky timeout.
        rsp_noack = 1; last_req_len = 0;
        @(posedge vga_clock); #1 done_cnt = 0;
        press(C_FWD);
        waited = 0;
        while (last_req_len == 0 && waited < 60) begin
            @(posedge vga_clock); waited++;
        end
        #1;
        check("timeout req length", last_req_len, ACKT);
        check("timeout flag", int'(query_timeout), 1);
        check("timeout req low", int'(wall_query_req), 0);
        check("timeout x", int'(player_x), 19);
        check("timeout move_done", done_cnt, 0);
        m_to = 1; rsp_noack = 0;
        ticks(CDF - 1);
        press(C_LEFT);
        repeat (10) @(posedge vga_clock);
        #1;
        check("cooldown holds dir", int'(player_dir), 2);
        check("cooldown holds move_done", done_cnt, 0);
        ticks(1);
        repeat (6) @(posedge vga_clock);
        #1;
        check("after cooldown dir", int'(player_dir), 3);
        check("after cooldown move_done", done_cnt, 1);
        m_dir = 3;
        ticks(CDF);
        repeat (4) @(posedge vga_clock);
        run_cmd("turn_w2", C_RIGHT, 0, 0, 0);

        // Reset while a query is outstanding.
        rsp_noack = 1; req_seen = 0;
        press(C_FWD);
        waited = 0;
        while (req_seen == 0 && waited < 20) begin
            @(posedge vga_clock); waited++;
        end
        check("mid-query req seen", int'(req_seen > 0), 1);
        repeat (3) @(posedge vga_clock);
        #2 reset = 1'b1;
        #1 check_reset_state("mid-query reset");
        repeat (2) @(posedge vga_clock);
        @(negedge vga_clock); reset = 1'b0;
        rsp_noack = 0;
        m_x = 0; m_y = 0; m_dir = 0; m_to = 0;

        // Coincident fwd + left: forward wins, heading unchanged.
        run_cmd("fwd+left", C_FWD | C_LEFT, 0, 2, 0);

        // Hold fwd across three cooldown periods.
        q_chk = 0; rsp_blk = 0; rsp_dly = 1; rsp_noack = 0;
        @(posedge vga_clock); #1;
        done_cnt = 0; key_fwd = 1'b1;
        for (k = 0; k < 3; k++) begin
            repeat (34) @(posedge vga_clock);
            #1;
            if (k == 2) key_fwd = 1'b0;
            ticks(CDF);
            repeat (4) @(posedge vga_clock);
        end
        #1;
`ifdef KEY_REPEAT_EN
        exp_steps = 3;
`else
        exp_steps = 1;
`endif
        check("hold x", int'(player_x), m_x + exp_steps);
        check("hold move_done", done_cnt, exp_steps);
        m_x = m_x + exp_steps;
        q_chk = 1;

        for (int i = 0; i < 40; i++) begin
            int r, mask;
            r = int'($urandom_range(0, 9));
            mask = (r < 6) ? C_FWD : ((r < 8) ? C_LEFT : C_RIGHT);
            run_cmd($sformatf("rnd%0d", i), mask, ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 6)), ($urandom_range(0, 11) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/player_motion_ctrl.md
Name: player_motion_ctrl

Overview:
- Upstream of the VGA rendering stage; owns player state and drives player_x, player_y and player_dir into it.
- Turns synchronised key presses into turn or step commands.
- Validates each forward step against the maze wall map through a request/acknowledge query port.
- Rate-limits actions to one per COOLDOWN_FRAMES frame ticks.

Parameters:
GRID_W, 20, maze width in cells; x range 0..GRID_W-1
GRID_H, 20, maze height in cells; y range 0..GRID_H-1
START_X, 0, player_x after reset
START_Y, 0, player_y after reset
START_DIR, 0, player_dir after reset (EAST)
COOLDOWN_FRAMES, 8, frame_tick pulses to wait after any action; legal range 1..255
ACK_TIMEOUT, 16, cycles to wait for wall_query_ack before forcing "blocked"

Ports:
vga_clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
key_fwd  in  1  raw async key, step forward
key_left  in  1  raw async key, rotate counter-clockwise
key_right  in  1  raw async key, rotate clockwise
frame_tick  in  1  one-cycle pulse per video frame
wall_query_req  out  1  wall lookup request
wall_query_x  out  5  current cell x for the lookup
wall_query_y  out  5  current cell y for the lookup
wall_query_dir  out  2  side of the cell being checked
wall_query_ack  in  1  lookup result valid this cycle
wall_blocked  in  1  1 = wall on the queried side; sampled only when ack = 1
player_x  out  5  current cell x
player_y  out  5  current cell y
player_dir  out  2  0 = EAST, 1 = NORTH, 2 = WEST, 3 = SOUTH
move_done  out  1  one-cycle pulse on every completed turn or step
query_timeout  out  1  sticky flag; set on ack timeout, cleared only by reset

Behaviour:
- Reset (async, all outputs):
  - player_x = START_X, player_y = START_Y, player_dir = START_DIR.
  - wall_query_req = 0, move_done = 0, query_timeout = 0.
  - Sync flops, counters and FSM = IDLE.
- Key inputs:
  - Each key passes a 2-flop synchroniser, then a rising-edge detector.
  - An edge is latched into a one-deep pending command register.
  - Priority when edges coincide: fwd > left > right; lower-priority edges that cycle are dropped.
  - The register holds only the newest command; edges arriving outside IDLE overwrite it.
- FSM states: IDLE, QUERY, STEP, COOLDOWN.
- IDLE, pending = left/right:
  - player_dir updates next cycle: left = dir+1 mod 4; right = dir-1 mod 4.
  - move_done pulses in that same cycle; pending clears; go to COOLDOWN.
- IDLE, pending = fwd:
  - Compute target = (x+1,y) E; (x,y-1) N; (x-1,y) W; (x,y+1) S.
  - Target outside 0..GRID_W-1 / 0..GRID_H-1: no query, no move, no move_done; pending clears; go to COOLDOWN.
  - Otherwise go to QUERY.
- QUERY:
  - wall_query_req = 1, with x, y, dir held stable at the current player values.
  - wall_query_ack is accepted from the first req cycle onward.
  - On ack: wall_blocked = 1 means no move, go to COOLDOWN, no move_done; wall_blocked = 0 means go to STEP.
  - req drops the cycle after ack.
  - No ack within ACK_TIMEOUT cycles (counted from the first req cycle): treat as blocked, set query_timeout, go to COOLDOWN.
- STEP: player_x/player_y take the target values; move_done pulses; go to COOLDOWN.
- COOLDOWN:
  - Counter loads COOLDOWN_FRAMES on entry and decrements on each frame_tick.
  - Return to IDLE in the cycle after the count reaches 0.
  - A frame_tick in the entry cycle is not counted.
- Latency:
  - Key edge to pending: 3 cycles (2 sync + 1 edge).
  - Turn: 1 cycle after IDLE sees pending.
  - Step: ack cycle + 1.
- Width rules:
  - Direction arithmetic is mod 4 on 2 bits.
  - Target coordinates are computed at 6 bits signed so that -1 and GRID_W are detectable.
- player_* outputs are registered and change only in STEP or on a turn; they are glitch-free to the renderer.

Optional Feature:
KEY_REPEAT_EN
- Defined: in IDLE, a key still held (synchronised level high) regenerates its command on COOLDOWN exit, using the same priority order; holding fwd steps once per cooldown period.
- Undefined: only rising edges generate commands; a held key acts exactly once until released.

Test Plan:
- Reset with defaults -> player (0,0), dir 0, req 0, move_done 0; assert reset mid-QUERY -> req drops immediately, state back to (0,0).
- From (5,5) dir 0, pulse key_left -> dir 1 after 4 cycles plus 1, move_done pulses once; then key_right twice (spaced by cooldown) -> dir 3.
- (5,5) dir 0, key_fwd, ack after 3 cycles with wall_blocked = 0 -> player_x = 6 at ack + 1, move_done pulses; with wall_blocked = 1 -> stays at (5,5), no pulse.
- (0,0) dir 2 (WEST), key_fwd -> no req ever asserted, position unchanged; (19,19) dir 3 -> same.
- key_fwd with ack never returned -> after 16 cycles query_timeout = 1, req = 0, no move; next command is accepted only after 8 frame_ticks.
- key_fwd and key_left rising in the same cycle -> forward handled, dir unchanged. With KEY_REPEAT_EN and fwd held over 3 cooldowns on an open corridor -> x advances by 3.
